// File: rtl/sparse_stream_compactor_if.sv
// Block-in / dense-group-out handshake bundle for the sparse stream compactor.
interface sparse_stream_compactor_if #(
  parameter int BITMASK_LENGTH = 8,
  parameter int ELEMENT_WIDTH  = 16,
  parameter int NUM_OUTPUT     = 2
);
  localparam int COUNT_BITWIDTH = $clog2(NUM_OUTPUT) + 1;

  logic                                in_valid;
  logic                                in_ready;
  logic [BITMASK_LENGTH-1:0]           in_bitmask;
  logic [BITMASK_LENGTH*ELEMENT_WIDTH-1:0] in_data;
  logic                                in_last;
  logic                                out_valid;
  logic                                out_ready;
  logic [NUM_OUTPUT*ELEMENT_WIDTH-1:0] out_data;
  logic [COUNT_BITWIDTH-1:0]           out_count;
  logic                                out_last;

  modport master (
    output in_valid, in_bitmask, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_last
  );
  modport slave (
    input  in_valid, in_bitmask, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_last
  );
endinterface

// File: rtl/sparse_stream_compactor.sv
// Packs the dense elements of masked sparse blocks into fixed-size groups,
// carrying a partial group across blocks and flushing it on the stream's last block.
module sparse_stream_compactor #(
  parameter int BITMASK_LENGTH = 8,
  parameter int ELEMENT_WIDTH  = 16,
  parameter int NUM_OUTPUT     = 2
) (
  input  logic                    clock,
  input  logic                    resetn,
  sparse_stream_compactor_if.slave bus
);
  localparam int COUNT_BITWIDTH = $clog2(NUM_OUTPUT) + 1;
  localparam int BL = BITMASK_LENGTH;
  localparam int EW = ELEMENT_WIDTH;
  localparam int N  = NUM_OUTPUT;
  localparam int CW = COUNT_BITWIDTH;

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH} state_t;

  state_t                state_q;
  logic                  in_ready_q;
  logic [BL-1:0]         m_q, m_d;
  logic [BL-1:0][EW-1:0] data_q;
  logic                  last_q;
  logic [CW-1:0]         r_q, need, take_cnt;
  logic [N-1:0][EW-1:0]  res_q, grp_d;
  logic                  out_valid_q, out_last_q;
  logic [N-1:0][EW-1:0]  out_data_q;
  logic [CW-1:0]         out_count_q;
  logic                  full, out_free;

  // Slots above r in the residual are kept zero, so grp_d is already
  // zero-padded whenever fewer than N elements are present.
  always_comb begin
    need     = CW'(N) - r_q;
    take_cnt = '0;
    m_d      = m_q;
    grp_d    = res_q;
    for (int i = 0; i < BL; i++) begin
      if (m_q[i] && (take_cnt < need)) begin
        for (int s = 0; s < N; s++)
          if (CW'(s) == r_q + take_cnt) grp_d[s] = data_q[i];
        m_d[i]   = 1'b0;
        take_cnt = take_cnt + CW'(1);
      end
    end
    full = (r_q + take_cnt) == CW'(N);
  end

  assign out_free = !out_valid_q || bus.out_ready;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      m_q         <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      r_q         <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.in_valid) begin
          data_q     <= bus.in_data;
          m_q        <= bus.in_bitmask;
          last_q     <= bus.in_last;
          in_ready_q <= 1'b0;
          state_q    <= SCAN;
        end
        SCAN: if (full) begin
          if (out_free) begin
            out_valid_q <= 1'b1;
            out_data_q  <= grp_d;
            out_count_q <= CW'(N);
            out_last_q  <= 1'b0;
            m_q         <= m_d;
            r_q         <= '0;
            res_q       <= '0;
          end
        end else begin
          // Mask exhausted: the partial group waits for the next block or the flush.
          res_q      <= grp_d;
          r_q        <= r_q + take_cnt;
          m_q        <= '0;
          state_q    <= last_q ? FLUSH : IDLE;
          in_ready_q <= !last_q;
        end
        FLUSH: if (out_free) begin
          out_valid_q <= 1'b1;
          out_data_q  <= res_q;
          out_count_q <= r_q;
          out_last_q  <= 1'b1;
          r_q         <= '0;
          res_q       <= '0;
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;
  assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_sparse_stream_compactor.sv
// Directed and randomized bench for sparse_stream_compactor against a queue-based packing model.
module tb_sparse_stream_compactor;
  localparam int BL = 8;
  localparam int EW = 16;
  localparam int N  = 2;
  localparam int CW = $clog2(N) + 1;

  typedef struct {
    logic [N*EW-1:0] data;
    logic [CW-1:0]   cnt;
    logic            last;
  } grp_t;

  logic clock = 1'b0;
  logic resetn;
  int   checks = 0;
  int   failures = 0;
  bit   rnd = 1'b0;

  logic [EW-1:0] pend[$];
  grp_t          exp_q[$];
  grp_t          got_q[$];

  sparse_stream_compactor_if #(.BITMASK_LENGTH(BL), .ELEMENT_WIDTH(EW), .NUM_OUTPUT(N)) bus ();

  sparse_stream_compactor #(.BITMASK_LENGTH(BL), .ELEMENT_WIDTH(EW), .NUM_OUTPUT(N)) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Capture accepted groups; a group stalled by out_ready=0 must not change.
  bit              have_prev = 1'b0;
  logic [N*EW-1:0] prev_data;
  logic [CW-1:0]   prev_cnt;
  logic            prev_last;
  always @(negedge clock) begin
    if (!resetn) begin
      have_prev <= 1'b0;
    end else begin
      if (have_prev) begin
        chk("hold_valid", bus.out_valid, 1'b1);
        chk("hold_data",  bus.out_data,  prev_data);
        chk("hold_count", bus.out_count, prev_cnt);
        chk("hold_last",  bus.out_last,  prev_last);
      end
      if (bus.out_valid && bus.out_ready)
        got_q.push_back('{data: bus.out_data, cnt: bus.out_count, last: bus.out_last});
      have_prev <= bus.out_valid && !bus.out_ready;
      prev_data <= bus.out_data;
      prev_cnt  <= bus.out_count;
      prev_last <= bus.out_last;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  // Reference: dense elements form one ordered stream, cut into groups of N.
  task automatic model_accept(input logic [BL-1:0] m, input logic [BL*EW-1:0] d, input logic l);
    grp_t g;
    int   s;
    for (int i = 0; i < BL; i++) if (m[i]) pend.push_back(d[i*EW +: EW]);
    while (pend.size() >= N) begin
      g.data = '0;
      for (int k = 0; k < N; k++) g.data[k*EW +: EW] = pend.pop_front();
      g.cnt  = CW'(N);
      g.last = 1'b0;
      exp_q.push_back(g);
    end
    if (l) begin
      g.data = '0;
      g.cnt  = CW'(pend.size());
      s = 0;
      while (pend.size() > 0) begin
        g.data[s*EW +: EW] = pend.pop_front();
        s++;
      end
      g.last = 1'b1;
      exp_q.push_back(g);
    end
  endtask

  task automatic send(input logic [BL-1:0] m, input logic [EW-1:0] base, input logic l);
    logic [BL*EW-1:0] d;
    int n;
    for (int i = 0; i < BL; i++) d[i*EW +: EW] = base + EW'(i);
    bus.in_valid   = 1'b1;
    bus.in_bitmask = m;
    bus.in_data    = d;
    bus.in_last    = l;
    n = 0;
    while (!bus.in_ready && n < 300) begin
      tick();
      n++;
    end
    chk("accept_timeout", n < 300, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    model_accept(m, d, l);
  endtask

  task automatic drain(input string tag);
    int n;
    rnd = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (!(got_q.size() >= exp_q.size() && bus.in_ready && !bus.out_valid) && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_drain_timeout"}, n < 300, 1'b1);
    chk({tag, "_ngroups"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk({tag, "_data"},  got_q[i].data, exp_q[i].data);
      chk({tag, "_count"}, got_q[i].cnt,  exp_q[i].cnt);
      chk({tag, "_last"},  got_q[i].last, exp_q[i].last);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_bitmask = '0; bus.in_data = '0; bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    chk("rst_in_ready",  bus.in_ready,  1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data",  bus.out_data,  '0);
    chk("rst_out_count", bus.out_count, '0);
    chk("rst_out_last",  bus.out_last,  1'b0);

    // Two dense elements: one group, two cycles after acceptance.
    bus.out_ready = 1'b1;
    send(8'b0000_0101, 16'h1000, 1'b0);
    chk("lat_t1_valid", bus.out_valid, 1'b0);
    tick();
    chk("lat_t2_valid", bus.out_valid, 1'b1);
    chk("lat_t2_data",  bus.out_data,  32'h1002_1000);
    chk("lat_t2_count", bus.out_count, 2);
    chk("lat_t2_last",  bus.out_last,  1'b0);
    tick();
    tick();
    chk("lat_ready_back", bus.in_ready, 1'b1);
    drain("single");

    // Residual carried across blocks, then an empty flush group.
    send(8'b0000_0111, 16'h1000, 1'b0);
    send(8'b1000_0000, 16'h2000, 1'b1);
    drain("carry");

    // Full block at full rate, then a long downstream stall mid-block.
    bus.out_ready = 1'b1;
    send(8'hFF, 16'h1000, 1'b0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("rate_valid", bus.out_valid, 1'b1);
    end
    send(8'hFF, 16'h2000, 1'b0);
    tick();
    tick();
    bus.out_ready = 1'b0;
    repeat (5) tick();
    bus.out_ready = 1'b1;
    drain("stall");

    // One residual element flushed by an all-zero final block.
    send(8'b0000_0001, 16'h1000, 1'b0);
    send(8'h00, 16'h2000, 1'b1);
    drain("flush1");

    // Reset in the middle of a block discards everything.
    bus.out_ready = 1'b0;
    send(8'hFF, 16'h1000, 1'b0);
    tick();
    resetn = 1'b0;
    #1;
    chk("midrst_valid", bus.out_valid, 1'b0);
    chk("midrst_data",  bus.out_data,  '0);
    chk("midrst_count", bus.out_count, '0);
    chk("midrst_last",  bus.out_last,  1'b0);
    tick();
    got_q.delete();
    exp_q.delete();
    pend.delete();
    resetn = 1'b1;
    chk("midrst_in_ready", bus.in_ready, 1'b1);
    send(8'b0000_0011, 16'h2000, 1'b1);
    drain("post_rst");

    // Random streams with random backpressure.
    rnd = 1'b1;
    for (int b = 0; b < 40; b++)
      send(8'($urandom), 16'h4000 + 16'(b << 4), (b == 39) || ($urandom_range(0, 3) == 0));
    drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sparse_stream_compactor.md
SPARSE_STREAM_COMPACTOR -- requirements
Module: sparse_stream_compactor

Interface
REQ-001 SHALL have parameter BITMASK_LENGTH, default 8, elements per input block.
REQ-002 SHALL have parameter ELEMENT_WIDTH, default 16, bits per element.
REQ-003 SHALL have parameter NUM_OUTPUT, default 2, elements per dense output group; NUM_OUTPUT <= BITMASK_LENGTH.
REQ-004 SHALL define COUNT_BITWIDTH = $clog2(NUM_OUTPUT)+1 as a localparam.
REQ-005 clock  input  1  single clock; all state changes on the rising edge.
REQ-006 resetn  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  input block valid.
REQ-008 in_ready  output  1  block accepted on a cycle where in_valid and in_ready are both high.
REQ-009 in_bitmask  input  BITMASK_LENGTH  little-endian density mask; bit i set means element i is dense.
REQ-010 in_data  input  BITMASK_LENGTH*ELEMENT_WIDTH  sparse block; element i occupies bits [(i+1)*ELEMENT_WIDTH-1 : i*ELEMENT_WIDTH].
REQ-011 in_last  input  1  final block of the stream.
REQ-012 out_valid  output  1  output group valid.
REQ-013 out_ready  input  1  downstream accepts the group.
REQ-014 out_data  output  NUM_OUTPUT*ELEMENT_WIDTH  dense group, slot 0 in the LSBs.
REQ-015 out_count  output  COUNT_BITWIDTH  number of meaningful slots; unused slots are zero.
REQ-016 out_last  output  1  final group of the stream.

Function
REQ-017 SHALL implement a state machine with states IDLE, SCAN and FLUSH; in_ready SHALL be 1 only in IDLE.
REQ-018 On acceptance, SHALL register in_data, in_bitmask (working mask M) and in_last, then enter SCAN.
REQ-019 SHALL keep a residual buffer R of r elements, 0 <= r < NUM_OUTPUT, persisting across blocks.
REQ-020 Each SCAN cycle: k = min(popcount(M), NUM_OUTPUT-r); take the k lowest-indexed set bits of M, in ascending index order.
REQ-021 If r+k == NUM_OUTPUT and the output register is free (out_valid==0 or out_ready==1): SHALL load out_data = R slots followed by the k taken elements, out_count = NUM_OUTPUT, out_last = 0; SHALL clear the k bits from M; SHALL set r = 0.
REQ-022 If r+k == NUM_OUTPUT and the output register is not free: SHALL stall with M and R unchanged.
REQ-023 If r+k < NUM_OUTPUT, M is exhausted: SHALL append the k elements to R and set r = r+k; then go to FLUSH if the held in_last is 1, else go to IDLE.
REQ-024 In FLUSH, when the output register is free: SHALL load R zero-padded, out_count = r (0 is legal), out_last = 1; SHALL clear r to 0 and go to IDLE.
REQ-025 Every stream terminated by in_last SHALL yield exactly one out_last group; full groups SHALL never carry out_last.
REQ-026 out_valid, out_data, out_count and out_last SHALL be registered, and SHALL stay stable while out_valid==1 and out_ready==0.
REQ-027 Latency: block accepted in cycle t SHALL produce its first group with out_valid high in cycle t+2.
REQ-028 With out_ready held at 1, SHALL sustain one full group per cycle.
REQ-029 An all-zero in_bitmask SHALL spend exactly one SCAN cycle and emit no full group.
REQ-030 Elements with mask bit 0 SHALL never appear on out_data.

Reset
REQ-031 While resetn==0: state = IDLE, r = 0, M = 0, out_valid = 0, out_data = 0, out_count = 0, out_last = 0.
REQ-032 Reset asserted mid-SCAN or mid-FLUSH SHALL discard the held block, R and any pending output group.
REQ-033 in_ready SHALL be 1 in the first cycle after resetn deasserts.

Verification (BITMASK_LENGTH=8, ELEMENT_WIDTH=16, NUM_OUTPUT=2; element i of block A = 0x1000+i, of block B = 0x2000+i)
REQ-034 Reset release -> all outputs 0, in_ready=1.
REQ-035 Block A, mask 8'b0000_0101, in_last=0 -> one group {0x1002,0x1000}, count=2, last=0, at t+2; then in_ready=1.
REQ-036 Block A mask 8'b0000_0111 last=0, then block B mask 8'b1000_0000 last=1 -> groups {0x1001,0x1000}, then {0x2007,0x1002}, then count=0 data=0 last=1.
REQ-037 Block A, mask 8'hFF, last=0, out_ready=1 -> 4 groups on consecutive cycles; then out_ready=0 for 5 cycles mid-stream -> data held stable, no loss, no duplication.
REQ-038 r=1 (0x1000), then block B mask 8'h00 last=1 -> group {0x0000,0x1000}, count=1, last=1.
REQ-039 resetn pulsed low during SCAN of a mask 8'hFF block -> outputs 0, r=0; the next stream starts clean, with no stale elements.
